// File: rtl/maindec_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle main decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package maindec_pkg;

  // Controller states; one per micro-step of the multi-cycle datapath.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_TRAP   = 4'd9
  } state_t;

  // Instruction classes the controller distinguishes.
  typedef enum logic [2:0] {
    OP_LOAD    = 3'd0,
    OP_STORE   = 3'd1,
    OP_CBZ     = 3'd2,
    OP_RTYPE   = 3'd3,
    OP_ILLEGAL = 3'd4
  } op_class_t;

  // Full 11-bit opcodes (instruction bits [31:21]).
  localparam logic [10:0] OPC_LDUR = 11'b111_1100_0010;
  localparam logic [10:0] OPC_STUR = 11'b111_1100_0000;
  localparam logic [10:0] OPC_ADD  = 11'b100_0101_1000;
  localparam logic [10:0] OPC_SUB  = 11'b110_0101_1000;
  localparam logic [10:0] OPC_AND  = 11'b100_0101_0000;
  localparam logic [10:0] OPC_ORR  = 11'b101_0101_0000;

  // CBZ is only 8 bits wide; the low three opcode bits belong to the immediate.
  localparam logic [10:0] OPC_CBZ_VAL  = 11'b101_1010_0000;
  localparam logic [10:0] OPC_CBZ_MASK = 11'b111_1111_1000;

  // ALU control class handed to the ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // True when the opcode is one of the register-register ALU instructions.
  function automatic logic is_rtype(input logic [10:0] op);
    return (op == OPC_ADD) || (op == OPC_SUB) || (op == OPC_AND) || (op == OPC_ORR);
  endfunction

endpackage

// File: rtl/op_classify.sv
// Combinational opcode classifier: Op -> {LOAD, STORE, CBZ, RTYPE, ILLEGAL}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input every cycle.
module op_classify
  import maindec_pkg::*;
(
  input  logic [10:0] op,
  output op_class_t   op_class
);

  // Priority order is irrelevant (patterns are disjoint); anything unmatched is illegal.
  always_comb begin
    op_class = OP_ILLEGAL;
    if (op == OPC_LDUR) begin
      op_class = OP_LOAD;
    end else if (op == OPC_STUR) begin
      op_class = OP_STORE;
    end else if ((op & OPC_CBZ_MASK) == OPC_CBZ_VAL) begin
      op_class = OP_CBZ;
    end else if (is_rtype(op)) begin
      op_class = OP_RTYPE;
    end
  end

endmodule

// File: rtl/maindec_mc.sv
// Multi-cycle LEGv8 main control FSM with memory-ready wait, timeout and retired count.
// Latency: 3 cycles (CBZ), 4 (R-type), 4+wait (STUR), 5+wait (LDUR) per instruction.
// Backpressure: MemRead/MemWrite held until mem_ready or TIMEOUT; ILLEGAL_TRAP_EN selects trap vs NOP.
module maindec_mc
  import maindec_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      Op,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [1:0]       ALUOp,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             mem_err,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  // Counter only needs to reach TIMEOUT-1; a timeout fires in that wait cycle.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state;
  state_t            state_next;
  op_class_t         op_class;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_expired;
  logic              retire;
  logic              timeout_hit;

  op_classify u_op_classify (
    .op       (Op),
    .op_class (op_class)
  );

  // A wait cycle is the last one allowed when the counter has seen TIMEOUT-1 prior waits.
  assign wait_expired = (TIMEOUT > 0) && !mem_ready && (wait_cnt == WAIT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state control decode; everything is forced low while reset is high.
  always_comb begin
    state_next  = state;
    Reg2Loc     = 1'b0;
    ALUSrc      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    ALUOp       = ALUOP_ADD;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCSrc       = 1'b0;
    retire      = 1'b0;
    timeout_hit = 1'b0;

    case (state)
      S_FETCH: begin
        IRWrite    = 1'b1;
        state_next = S_DECODE;
      end

      S_DECODE: begin
        case (op_class)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXEC;
          OP_CBZ:            state_next = S_BRANCH;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_next = S_TRAP;
`else
            // Illegal opcode retires as a NOP without counting as an instruction.
            PCWrite    = 1'b1;
            PCSrc      = 1'b0;
            state_next = S_FETCH;
`endif
          end
        endcase
      end

      S_MEMADR: begin
        ALUSrc     = 1'b1;
        ALUOp      = ALUOP_ADD;
        Reg2Loc    = (op_class == OP_STORE);
        state_next = (op_class == OP_STORE) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          state_next = S_MEMWB;
        end else if (wait_expired) begin
          // Abandon the load: skip write-back and move on to the next instruction.
          PCWrite     = 1'b1;
          PCSrc       = 1'b0;
          timeout_hit = 1'b1;
          state_next  = S_FETCH;
        end
      end

      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        PCWrite    = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_MEMWR: begin
        MemWrite = 1'b1;
        Reg2Loc  = 1'b1;
        if (mem_ready) begin
          PCWrite    = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end else if (wait_expired) begin
          PCWrite     = 1'b1;
          PCSrc       = 1'b0;
          timeout_hit = 1'b1;
          state_next  = S_FETCH;
        end
      end

      S_EXEC: begin
        ALUOp      = ALUOP_FUNCT;
        ALUSrc     = 1'b0;
        state_next = S_ALUWB;
      end

      S_ALUWB: begin
        RegWrite   = 1'b1;
        PCWrite    = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_BRANCH: begin
        Reg2Loc    = 1'b1;
        ALUOp      = ALUOP_PASSB;
        PCWrite    = 1'b1;
        PCSrc      = Zero;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        // Parked with all writes low until reset.
        state_next = S_TRAP;
`else
        state_next = S_FETCH;
`endif
      end

      default: begin
        state_next = S_FETCH;
      end
    endcase

    if (reset) begin
      Reg2Loc     = 1'b0;
      ALUSrc      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      ALUOp       = ALUOP_ADD;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCSrc       = 1'b0;
      retire      = 1'b0;
      timeout_hit = 1'b0;
    end
  end

  // Wait counter: cleared in MEMADR (sole entry to MEMRD/MEMWR), counts cycles without mem_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == S_MEMADR) begin
      wait_cnt <= '0;
    end else if ((TIMEOUT > 0) && !mem_ready && ((state == S_MEMRD) || (state == S_MEMWR))) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret <= '0;
    end else if (retire) begin
      instret <= instret + CNT_W'(1);
    end
  end

  // Sticky memory-timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_err <= 1'b0;
    end else if (timeout_hit) begin
      mem_err <= 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky trap flag, raised on the same edge that enters TRAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      trap <= 1'b0;
    end else if ((state == S_DECODE) && (op_class == OP_ILLEGAL)) begin
      trap <= 1'b1;
    end
  end
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_maindec_mc.sv
// Scoreboard bench for maindec_mc: per-cycle expected control vectors, checked by a monitor.
// Latency: stimulus pushes one expectation per cycle; monitor pops at the falling edge.
// Backpressure: mem_ready driven by directed vectors (ready, stalls, timeouts).
module tb_maindec_mc;

  // Control vector bit order:
  // {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp[1:0], IRWrite, PCWrite, PCSrc}
  localparam logic [10:0] C_IDLE   = 11'b000_000_00_000;
  localparam logic [10:0] C_FETCH  = 11'b000_000_00_100;
  localparam logic [10:0] C_ADR_LD = 11'b010_000_00_000;
  localparam logic [10:0] C_ADR_ST = 11'b110_000_00_000;
  localparam logic [10:0] C_MEMRD  = 11'b000_010_00_000;
  localparam logic [10:0] C_RD_TO  = 11'b000_010_00_010;
  localparam logic [10:0] C_MEMWB  = 11'b001_100_00_010;
  localparam logic [10:0] C_MEMWR  = 11'b100_001_00_000;
  localparam logic [10:0] C_WR_END = 11'b100_001_00_010;
  localparam logic [10:0] C_EXEC   = 11'b000_000_10_000;
  localparam logic [10:0] C_ALUWB  = 11'b000_100_00_010;
  localparam logic [10:0] C_BR_T   = 11'b100_000_01_011;
  localparam logic [10:0] C_BR_NT  = 11'b100_000_01_010;
`ifndef ILLEGAL_TRAP_EN
  localparam logic [10:0] C_NOP    = 11'b000_000_00_010;
`endif

  localparam logic [10:0] LDUR = 11'b111_1100_0010;
  localparam logic [10:0] STUR = 11'b111_1100_0000;
  localparam logic [10:0] CBZ  = 11'b101_1010_0101;
  localparam logic [10:0] ADD  = 11'b100_0101_1000;
  localparam logic [10:0] SUB  = 11'b110_0101_1000;
  localparam logic [10:0] ANDI = 11'b100_0101_0000;
  localparam logic [10:0] ORR  = 11'b101_0101_0000;
  localparam logic [10:0] ILL  = 11'b101_1111_0000;

  typedef struct {
    int          cyc;
    logic [10:0] ctrl;
    logic        err;
    logic        trp;
    logic [31:0] ir;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] Op = '0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
  logic [1:0]  ALUOp;
  logic        IRWrite, PCWrite, PCSrc, mem_err, trap;
  logic [31:0] instret;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_cyc = 0;

  maindec_mc #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Zero      (Zero),
    .mem_ready (mem_ready),
    .Reg2Loc   (Reg2Loc),
    .ALUSrc    (ALUSrc),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ALUOp     (ALUOp),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .PCSrc     (PCSrc),
    .mem_err   (mem_err),
    .trap      (trap),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue what that cycle must show.
  task automatic step(input logic rst, input logic [10:0] op, input logic z, input logic rdy,
                      input logic [10:0] ctrl, input logic err, input logic trp, input int ir);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    Op        = op;
    Zero      = z;
    mem_ready = rdy;
    n_cyc++;
    e.cyc  = n_cyc;
    e.ctrl = ctrl;
    e.err  = err;
    e.trp  = trp;
    e.ir   = ir;
    sb.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation at each falling edge.
  initial begin
    exp_t        e;
    logic [10:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, IRWrite, PCWrite, PCSrc};
        n_checks++;
        if (act !== e.ctrl) begin
          n_fail++;
          $display("FAIL ctrl cycle %0d: got %b expected %b", e.cyc, act, e.ctrl);
        end
        n_checks++;
        if (mem_err !== e.err) begin
          n_fail++;
          $display("FAIL mem_err cycle %0d: got %b expected %b", e.cyc, mem_err, e.err);
        end
        n_checks++;
        if (trap !== e.trp) begin
          n_fail++;
          $display("FAIL trap cycle %0d: got %b expected %b", e.cyc, trap, e.trp);
        end
        n_checks++;
        if (instret !== e.ir) begin
          n_fail++;
          $display("FAIL instret cycle %0d: got %0d expected %0d", e.cyc, instret, e.ir);
        end
      end
    end
  end

  // Directed stimulus with hand-computed per-cycle expectations.
  initial begin
    // Reset cycle, then the first FETCH.
    step(1, ADD, 0, 0, C_IDLE, 0, 0, 0);
    step(0, ADD, 0, 0, C_FETCH, 0, 0, 0);
    // ADD: DECODE, EXEC, ALUWB.
    step(0, ADD, 0, 0, C_IDLE, 0, 0, 0);
    step(0, ADD, 0, 0, C_EXEC, 0, 0, 0);
    step(0, ADD, 0, 0, C_ALUWB, 0, 0, 0);
    // LDUR with three stall cycles before mem_ready.
    step(0, LDUR, 0, 0, C_FETCH, 0, 0, 1);
    step(0, LDUR, 0, 0, C_IDLE, 0, 0, 1);
    step(0, LDUR, 0, 0, C_ADR_LD, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, LDUR, 0, 0, C_MEMRD, 0, 0, 1);
    step(0, LDUR, 0, 1, C_MEMRD, 0, 0, 1);
    step(0, LDUR, 0, 0, C_MEMWB, 0, 0, 1);
    // CBZ taken, then not taken.
    step(0, CBZ, 0, 0, C_FETCH, 0, 0, 2);
    step(0, CBZ, 1, 0, C_IDLE, 0, 0, 2);
    step(0, CBZ, 1, 0, C_BR_T, 0, 0, 2);
    step(0, CBZ, 0, 0, C_FETCH, 0, 0, 3);
    step(0, CBZ, 0, 0, C_IDLE, 0, 0, 3);
    step(0, CBZ, 0, 0, C_BR_NT, 0, 0, 3);
    // SUB, AND, ORR.
    step(0, SUB, 0, 0, C_FETCH, 0, 0, 4);
    step(0, SUB, 0, 0, C_IDLE, 0, 0, 4);
    step(0, SUB, 0, 0, C_EXEC, 0, 0, 4);
    step(0, SUB, 0, 0, C_ALUWB, 0, 0, 4);
    step(0, ANDI, 0, 0, C_FETCH, 0, 0, 5);
    step(0, ANDI, 0, 0, C_IDLE, 0, 0, 5);
    step(0, ANDI, 0, 0, C_EXEC, 0, 0, 5);
    step(0, ANDI, 0, 0, C_ALUWB, 0, 0, 5);
    step(0, ORR, 0, 0, C_FETCH, 0, 0, 6);
    step(0, ORR, 0, 0, C_IDLE, 0, 0, 6);
    step(0, ORR, 0, 0, C_EXEC, 0, 0, 6);
    step(0, ORR, 0, 0, C_ALUWB, 0, 0, 6);
    // STUR completing in its first MEMWR cycle.
    step(0, STUR, 0, 0, C_FETCH, 0, 0, 7);
    step(0, STUR, 0, 0, C_IDLE, 0, 0, 7);
    step(0, STUR, 0, 0, C_ADR_ST, 0, 0, 7);
    step(0, STUR, 0, 1, C_WR_END, 0, 0, 7);
    // STUR that never gets mem_ready: 16 MemWrite cycles, then mem_err, no retire.
    step(0, STUR, 0, 0, C_FETCH, 0, 0, 8);
    step(0, STUR, 0, 0, C_IDLE, 0, 0, 8);
    step(0, STUR, 0, 0, C_ADR_ST, 0, 0, 8);
    for (int i = 0; i < 15; i++) step(0, STUR, 0, 0, C_MEMWR, 0, 0, 8);
    step(0, STUR, 0, 0, C_WR_END, 0, 0, 8);
    // LDUR whose mem_ready lands exactly in the 16th wait cycle: completes normally.
    step(0, LDUR, 0, 0, C_FETCH, 1, 0, 8);
    step(0, LDUR, 0, 0, C_IDLE, 1, 0, 8);
    step(0, LDUR, 0, 0, C_ADR_LD, 1, 0, 8);
    for (int i = 0; i < 15; i++) step(0, LDUR, 0, 0, C_MEMRD, 1, 0, 8);
    step(0, LDUR, 0, 1, C_MEMRD, 1, 0, 8);
    step(0, LDUR, 0, 0, C_MEMWB, 1, 0, 8);
    // LDUR timing out: no MEMWB, no retire.
    step(0, LDUR, 0, 0, C_FETCH, 1, 0, 9);
    step(0, LDUR, 0, 0, C_IDLE, 1, 0, 9);
    step(0, LDUR, 0, 0, C_ADR_LD, 1, 0, 9);
    for (int i = 0; i < 15; i++) step(0, LDUR, 0, 0, C_MEMRD, 1, 0, 9);
    step(0, LDUR, 0, 0, C_RD_TO, 1, 0, 9);
    // Reset in the 2nd MEMRD cycle: request dropped immediately, counters cleared after.
    step(0, LDUR, 0, 0, C_FETCH, 1, 0, 9);
    step(0, LDUR, 0, 0, C_IDLE, 1, 0, 9);
    step(0, LDUR, 0, 0, C_ADR_LD, 1, 0, 9);
    step(0, LDUR, 0, 0, C_MEMRD, 1, 0, 9);
    step(1, LDUR, 0, 0, C_IDLE, 1, 0, 9);
    // Illegal opcode.
    step(0, ILL, 0, 0, C_FETCH, 0, 0, 0);
`ifdef ILLEGAL_TRAP_EN
    step(0, ILL, 0, 0, C_IDLE, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, ILL, 0, 1, C_IDLE, 0, 1, 0);
    step(1, ILL, 0, 0, C_IDLE, 0, 1, 0);
`else
    step(0, ILL, 0, 0, C_NOP, 0, 0, 0);
`endif
    // Normal operation afterwards.
    step(0, ADD, 0, 0, C_FETCH, 0, 0, 0);
    step(0, ADD, 0, 0, C_IDLE, 0, 0, 0);
    step(0, ADD, 0, 0, C_EXEC, 0, 0, 0);
    step(0, ADD, 0, 0, C_ALUWB, 0, 0, 0);
    step(0, ADD, 0, 0, C_FETCH, 0, 0, 1);

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #2;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
